// File: rtl/chip8_audio_pkg.sv
// Shared types and constants for the CHIP-8 audio path (sound timer, tone
// generator, delta-sigma DAC front end).
package chip8_audio_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ATTACK  = 2'd1,
      SUSTAIN = 2'd2,
      RELEASE = 2'd3
   } env_state_t;

   localparam logic [7:0] SILENCE = 8'h80;

   // Defaults for the 8 MHz system clock
   localparam int unsigned DEF_TICK_DIV   = 133333;
   localparam int unsigned DEF_SAMPLE_DIV = 1000;
   localparam int unsigned DEF_TONE_HALF  = 8;
   localparam int unsigned DEF_AMP_MAX    = 127;
   localparam int unsigned DEF_ENV_STEP   = 8;

   // Offset-binary square-wave sample: high half above silence, low half below.
   function automatic logic [7:0] tone_sample(input logic pol, input logic [6:0] amp);
      logic [8:0] s;
      if (pol) s = {1'b0, SILENCE} - {2'b00, amp};
      else     s = {1'b0, SILENCE} + {2'b00, amp};
      return s[7:0];
   endfunction

endpackage

// File: rtl/chip8_sound_gen_strobe_div.sv
// Free-running 0..DIV-1 prescaler; strobe is high for the cycle the count sits
// at its terminal value.
module strobe_div #(
   parameter int unsigned DIV = 2
) (
   input  logic clk,
   input  logic reset,
   output logic strobe
);

   localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   assign strobe = (cnt == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       cnt <= '0;
      else if (strobe) cnt <= '0;
      else             cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/chip8_sound_gen.sv
// CHIP-8 sound timer plus square-wave tone generator with amplitude envelope.
// Define CHIP8_SOUND_ENVELOPE_EN for the attack/release ramp; otherwise the
// gate switches the amplitude straight between 0 and AMP_MAX.
module chip8_sound_gen
   import chip8_audio_pkg::*;
#(
   parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
   parameter int unsigned SAMPLE_DIV = DEF_SAMPLE_DIV,
   parameter int unsigned TONE_HALF  = DEF_TONE_HALF,
   parameter int unsigned AMP_MAX    = DEF_AMP_MAX,
   parameter int unsigned ENV_STEP   = DEF_ENV_STEP
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       st_we,
   input  logic [7:0] st_wdata,
   input  logic       mute,
   output logic [7:0] st_value,
   output logic       active,
   output logic [7:0] sample,
   output logic       sample_valid
);

`ifdef CHIP8_SOUND_ENVELOPE_EN
   localparam bit ENV_EN = 1'b1;
`else
   localparam bit ENV_EN = 1'b0;
`endif

   // A full-scale step turns the ramp into a single-strobe jump, so the same
   // FSM covers both builds and ATTACK/RELEASE simply never get entered.
   localparam logic [6:0] AMP7  = 7'(AMP_MAX);
   localparam logic [6:0] STEP7 = ENV_EN ? 7'(ENV_STEP) : 7'(AMP_MAX);
   localparam int unsigned PW   = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
   localparam logic [PW-1:0] PH_LAST = PW'(TONE_HALF - 1);

   logic tick, strobe, gate;

   strobe_div #(.DIV(TICK_DIV)) u_tick_div (
      .clk    (clk),
      .reset  (reset),
      .strobe (tick)
   );

   strobe_div #(.DIV(SAMPLE_DIV)) u_sample_div (
      .clk    (clk),
      .reset  (reset),
      .strobe (strobe)
   );

   // Sound timer: a CPU write takes priority over a same-cycle tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                          st_value <= 8'd0;
      else if (st_we)                     st_value <= st_wdata;
      else if (tick && st_value != 8'd0)  st_value <= st_value - 8'd1;
   end

   assign active = (st_value != 8'd0);
   assign gate   = active & ~mute;

   env_state_t    state, state_n;
   logic [6:0]    amp, amp_n, amp_up, amp_dn;
   logic [7:0]    up_sum;
   logic [PW-1:0] phase, phase_n;
   logic          pol, pol_n;

   always_comb begin
      up_sum = {1'b0, amp} + {1'b0, STEP7};
      amp_up = (up_sum >= {1'b0, AMP7}) ? AMP7 : up_sum[6:0];
      amp_dn = (amp <= STEP7) ? 7'd0 : (amp - STEP7);
   end

   always_comb begin
      state_n = state;
      amp_n   = amp;
      phase_n = phase;
      pol_n   = pol;
      if (strobe) begin
         unique case (state)
            IDLE: begin
               amp_n = 7'd0;
               if (gate) begin
                  amp_n   = amp_up;
                  state_n = (amp_up == AMP7) ? SUSTAIN : ATTACK;
               end
            end
            ATTACK: begin
               if (!gate) begin
                  state_n = RELEASE;
               end else begin
                  amp_n = amp_up;
                  if (amp_up == AMP7) state_n = SUSTAIN;
               end
            end
            SUSTAIN: begin
               amp_n = AMP7;
               if (!gate) begin
                  amp_n   = amp_dn;
                  state_n = (amp_dn == 7'd0) ? IDLE : RELEASE;
               end
            end
            RELEASE: begin
               if (gate) begin
                  state_n = ATTACK;
               end else begin
                  amp_n = amp_dn;
                  if (amp_dn == 7'd0) state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase

         // Landing in IDLE re-arms the tone to start on its high half.
         if (state_n == IDLE) begin
            phase_n = '0;
            pol_n   = 1'b0;
         end else if (phase == PH_LAST) begin
            phase_n = '0;
            pol_n   = ~pol;
         end else begin
            phase_n = phase + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         amp          <= 7'd0;
         phase        <= '0;
         pol          <= 1'b0;
         sample       <= SILENCE;
         sample_valid <= 1'b0;
      end else begin
         state        <= state_n;
         amp          <= amp_n;
         phase        <= phase_n;
         pol          <= pol_n;
         sample_valid <= strobe;
         if (strobe) sample <= tone_sample(pol, amp_n);
      end
   end

endmodule

// File: tb/tb_chip8_sound_gen.sv
// Directed bench for chip8_sound_gen with small dividers; expectations for the
// tone shape follow whether CHIP8_SOUND_ENVELOPE_EN is defined.
module tb_chip8_sound_gen;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       st_we = 1'b0;
   logic [7:0] st_wdata = 8'd0;
   logic       mute = 1'b0;
   logic [7:0] st_value;
   logic       active;
   logic [7:0] sample;
   logic       sample_valid;

   int n_cmp = 0;
   int n_err = 0;

   chip8_sound_gen #(
      .TICK_DIV   (100),
      .SAMPLE_DIV (10),
      .TONE_HALF  (2),
      .AMP_MAX    (127),
      .ENV_STEP   (64)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .st_we        (st_we),
      .st_wdata     (st_wdata),
      .mute         (mute),
      .st_value     (st_value),
      .active       (active),
      .sample       (sample),
      .sample_valid (sample_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(output logic [7:0] s, output int cyc);
      logic found;
      found = 1'b0;
      s = 8'h00;
      cyc = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         cyc++;
         if (sample_valid) begin
            s = sample;
            found = 1'b1;
            break;
         end
      end
      chk("sample_valid_seen", 32'(found), 32'd1);
   endtask

   task automatic wait_st(output logic [7:0] v, output int cyc);
      logic [7:0] prev;
      logic       found;
      prev = st_value;
      v = prev;
      found = 1'b0;
      cyc = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         cyc++;
         if (st_value != prev) begin
            v = st_value;
            found = 1'b1;
            break;
         end
      end
      chk("st_change_seen", 32'(found), 32'd1);
   endtask

   task automatic write_st(input logic [7:0] v);
      st_we = 1'b1;
      st_wdata = v;
      @(posedge clk); #1;
      st_we = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   logic [7:0] exp_tone [5];
   logic [7:0] exp_rel  [3];

   initial begin
      logic [7:0] s;
      logic [7:0] v;
      int         cyc;

`ifdef CHIP8_SOUND_ENVELOPE_EN
      exp_tone = '{8'hC0, 8'hFF, 8'h01, 8'h01, 8'hFF};
      exp_rel  = '{8'hBF, 8'h80, 8'h80};
`else
      exp_tone = '{8'hFF, 8'hFF, 8'h01, 8'h01, 8'hFF};
      exp_rel  = '{8'h80, 8'h80, 8'h80};
`endif

      // Reset state
      #12;
      chk("rst_sample", 32'(sample), 32'h80);
      chk("rst_valid", 32'(sample_valid), 32'd0);
      chk("rst_st", 32'(st_value), 32'd0);
      chk("rst_active", 32'(active), 32'd0);
      @(posedge clk); #1 reset = 1'b0;

      // Idle: silence every 10 cycles
      wait_valid(s, cyc);
      chk("idle_sample0", 32'(s), 32'h80);
      wait_valid(s, cyc);
      chk("idle_gap1", 32'(cyc), 32'd10);
      chk("idle_sample1", 32'(s), 32'h80);
      wait_valid(s, cyc);
      chk("idle_gap2", 32'(cyc), 32'd10);
      chk("idle_active", 32'(active), 32'd0);

      // Countdown 3 -> 0, one tick per 100 cycles
      write_st(8'd3);
      chk("cd_st3", 32'(st_value), 32'd3);
      chk("cd_active1", 32'(active), 32'd1);
      wait_st(v, cyc);
      chk("cd_st2", 32'(v), 32'd2);
      wait_st(v, cyc);
      chk("cd_st1", 32'(v), 32'd1);
      chk("cd_gap1", 32'(cyc), 32'd100);
      wait_st(v, cyc);
      chk("cd_st0", 32'(v), 32'd0);
      chk("cd_gap0", 32'(cyc), 32'd100);
      chk("cd_active0", 32'(active), 32'd0);
      repeat (150) @(posedge clk);
      #1;
      chk("cd_hold_st", 32'(st_value), 32'd0);
      chk("cd_hold_active", 32'(active), 32'd0);

      // Write lands in the same cycle as a tick
      do_reset();
      write_st(8'd9);
      wait_st(v, cyc);
      chk("wt_st8", 32'(v), 32'd8);
      repeat (99) @(posedge clk);
      #1;
      st_we = 1'b1;
      st_wdata = 8'd4;
      @(posedge clk); #1;
      st_we = 1'b0;
      chk("wt_write_wins", 32'(st_value), 32'd4);
      wait_st(v, cyc);
      chk("wt_next_dec", 32'(v), 32'd3);
      chk("wt_next_gap", 32'(cyc), 32'd100);

      // Tone shape and release
      do_reset();
      write_st(8'd50);
      for (int k = 0; k < 5; k++) begin
         wait_valid(s, cyc);
         chk($sformatf("tone_s%0d", k), 32'(s), 32'(exp_tone[k]));
      end
      write_st(8'd0);
      for (int k = 0; k < 3; k++) begin
         wait_valid(s, cyc);
         chk($sformatf("rel_s%0d", k), 32'(s), 32'(exp_rel[k]));
      end

      // Mute keeps silence while ST still counts
      do_reset();
      mute = 1'b1;
      write_st(8'd50);
      for (int k = 0; k < 4; k++) begin
         wait_valid(s, cyc);
         chk($sformatf("mute_s%0d", k), 32'(s), 32'h80);
      end
      wait_st(v, cyc);
      chk("mute_st_dec", 32'(v), 32'd49);
      mute = 1'b0;

      // Reset in the middle of a sustained tone
      do_reset();
      write_st(8'd50);
      for (int k = 0; k < 6; k++) wait_valid(s, cyc);
      chk("sus_s5", 32'(s), 32'hFF);
      reset = 1'b1;
      #2;
      chk("mid_rst_sample", 32'(sample), 32'h80);
      chk("mid_rst_st", 32'(st_value), 32'd0);
      chk("mid_rst_active", 32'(active), 32'd0);
      @(posedge clk); #1;
      chk("mid_rst_sample_cyc", 32'(sample), 32'h80);
      chk("mid_rst_valid_cyc", 32'(sample_valid), 32'd0);
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/chip8_sound_gen.md
# chip8_sound_gen

CHIP-8 sound-timer and tone-sample generator. Holds the sound timer (ST) written by the CPU, decrements it at 60 Hz, and while ST is non-zero produces an 8-bit unsigned square-wave sample stream with a click-free amplitude envelope. Sits directly upstream of the delta-sigma audio DAC, which consumes `sample` as `{2'b00, sample}`.

## Interface
- `TICK_DIV`, 133333: clk cycles per 60 Hz timer tick (8 MHz / 60).
- `SAMPLE_DIV`, 1000: clk cycles per sample strobe (8 kHz at 8 MHz).
- `TONE_HALF`, 8: samples per half tone period (500 Hz default).
- `AMP_MAX`, 127: sustain amplitude, 0..127.
- `ENV_STEP`, 8: amplitude change per sample during attack/release, 1..127.
- `clk` in 1: system clock, 8 MHz.
- `reset` in 1: asynchronous, active-high.
- `st_we` in 1: CPU write strobe for ST (LD ST,Vx), one cycle.
- `st_wdata` in 8: value written to ST.
- `mute` in 1: forces the gate off; ST keeps counting.
- `st_value` out 8: current ST.
- `active` out 1: ST != 0.
- `sample` out 8: unsigned sample, silence = 0x80.
- `sample_valid` out 1: one-cycle pulse when `sample` updates.

## Operation
- Reset values: `st_value`=0, `active`=0, `sample`=0x80, `sample_valid`=0; prescalers, phase, amplitude = 0; FSM = IDLE.
- Tick prescaler: free-running 0..TICK_DIV-1. Tick = count at TICK_DIV-1. On tick, ST decrements if non-zero; it never wraps below 0.
- `st_we`: ST <= `st_wdata` next edge. Write and tick in the same cycle: the write wins, with no decrement. Writing 0 stops the tone via release.
- gate = `active` & ~`mute`.
- Sample prescaler: free-running 0..SAMPLE_DIV-1. Strobe = count at SAMPLE_DIV-1. The FSM, amplitude and phase update only on a strobe.
- FSM states:
  - IDLE: amp=0 and phase counter held at 0. Gate=1 → ATTACK.
  - ATTACK: amp += ENV_STEP, saturating at AMP_MAX. Reaching AMP_MAX → SUSTAIN. Gate=0 → RELEASE, with no amp change that strobe.
  - SUSTAIN: amp=AMP_MAX. Gate=0 → RELEASE.
  - RELEASE: amp -= ENV_STEP, saturating at 0. Reaching 0 → IDLE. Gate=1 → ATTACK.
- Phase: counts strobes 0..TONE_HALF-1 outside IDLE. On wrap, the polarity bit toggles. IDLE clears the polarity to 0 (high half first).
- Sample = polarity 0 ? 0x80 + amp : 0x80 − amp. Compute at 9 bits; the result range is 0x01..0xFF, so there is no overflow.

## Timing
- `sample` and `sample_valid` are registered. Both update on the edge after the strobe cycle, using the amp/state values computed at that strobe. `sample_valid` is high exactly one cycle per strobe, including in IDLE (sample 0x80).
- `st_value` and `active` reflect a write or decrement one cycle after the `st_we`/tick cycle.
- Gate-to-first-nonzero-sample latency is up to SAMPLE_DIV+1 cycles.
- Asserting `reset` mid-tone immediately returns every output to its reset value. There is no release ramp.

## Configuration
- `CHIP8_SOUND_ENVELOPE_EN` defined: ATTACK/RELEASE ramp as above.
- Not defined: ENV_STEP is ignored. IDLE→SUSTAIN with amp=AMP_MAX on the first gated strobe, and SUSTAIN→IDLE with amp=0 on the first ungated strobe. ATTACK/RELEASE are unreachable.

## Structure
- Package `chip8_audio_pkg`:
  - FSM state enum (IDLE, ATTACK, SUSTAIN, RELEASE).
  - `SILENCE` = 8'h80.
  - Default divider constants for the 8 MHz clock.
- Sub-module `strobe_div` (parameter DIV; ports `clk`, `reset`, `strobe`): instantiated twice, for tick and sample.

## Test plan
Bench overrides: TICK_DIV=100, SAMPLE_DIV=10, TONE_HALF=2, AMP_MAX=127, ENV_STEP=64.
- Reset, no writes → `sample_valid` every 10 cycles with `sample`=0x80; `active`=0.
- Write ST=3 → `st_value` reaches 2, 1, 0 on three consecutive ticks, 100 cycles apart. `active` falls with the last, then stays 0.
- Write ST=5 (envelope on) → sample sequence 0xC0, 0xFF, 0x01, 0x01, 0xFF, … ; amp goes 64, 127 (saturated), SUSTAIN.
- Write ST=0 during SUSTAIN → amp 63 then 0; sample returns to 0x80 and FSM reaches IDLE within 2 strobes.
- `st_we` in the same cycle as a tick with ST=9, wdata=4 → `st_value`=4, not 3.
- `mute`=1 with ST=50 → `sample` stays 0x80 and ST still decrements. Assert `reset` mid-SUSTAIN → next cycle `sample`=0x80 and `st_value`=0.
- Without `CHIP8_SOUND_ENVELOPE_EN` → first gated sample is 0xFF; after ST=0 the first ungated sample is 0x80.
